ifu_fetch_queue: RTL
====================

// Module: ifu_fetch_queue
// PURPOSE
// - Instruction fetch queue between the IFU (producer of ifu_valid/ifu_pc/ifu_inst) and the decode stage.
// - Decouples IFU issue rate from decode acceptance.
// - FIFO of {pc, inst} pairs with valid/ready toward decode, flush on redirect, overflow detection.
// - The IFU has no backpressure input. ifq_ready is advisory, and drops are flagged.
// PARAMETERS
// - PC_WIDTH    32  width of each PC entry
// - INST_WIDTH  32  width of each instruction entry
// - DEPTH       4   number of entries; power of 2, >= 2
// PORTS
// - clk           in   1                  clock, rising edge
// - rst_n         in   1                  reset, asynchronous, active-low
// - ifu_valid     in   1                  IFU presents an instruction this cycle
// - ifu_pc        in   PC_WIDTH           PC of the presented instruction
// - ifu_inst      in   INST_WIDTH         presented instruction word
// - ifq_ready     out  1                  queue not full (= count != DEPTH)
// - flush         in   1                  discard all entries (branch/exception redirect)
// - dec_valid     out  1                  head entry valid toward decode
// - dec_pc        out  PC_WIDTH           head entry PC; 0 when dec_valid = 0
// - dec_inst      out  INST_WIDTH         head entry instruction; 0 when dec_valid = 0
// - dec_ready     in   1                  decode accepts the head this cycle
// - ifq_count     out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// - ifq_overflow  out  1                  sticky: an IFU push was dropped
// BEHAVIOUR
// - Reset (async assert): count=0, rd_ptr=wr_ptr=0, ifq_overflow=0, so dec_valid=0, dec_pc=0, dec_inst=0, ifq_ready=1.
//   Storage array is not reset; it is qualified by count.
// - pop  = dec_valid & dec_ready.
// - push = ifu_valid & (count != DEPTH | pop). A push and pop in the same cycle on a full queue both succeed.
// - Drop condition: ifu_valid & count == DEPTH & ~pop. The entry is discarded, ifq_overflow <= 1, and count is unchanged.
// - ifq_overflow clears only on reset.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
// - count updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
// - Order is strictly FIFO. dec_pc/dec_inst come from entry[rd_ptr] while count != 0.
// - dec_valid = (count != 0) without bypass. All decode outputs derive from registers, with no combinational path from ifu_* inputs.
// - Latency (no bypass): push at cycle N, dec_valid at cycle N+1 at the earliest.
// - flush has priority over push and pop in the same cycle.
//   Next cycle: count=0, pointers=0, dec_valid=0. Any push or pop in the flush cycle is discarded and has no effect.
//   ifq_overflow is not affected by flush.
// - dec_valid may not drop without a pop or flush. Once dec_valid=1, dec_pc/dec_inst hold until accepted.
// - No state machine beyond the occupancy counter; states are EMPTY / PARTIAL / FULL, implied by count.
// CONFIGURATION
// - Macro IFQ_BYPASS_EN.
// - Defined: when count==0 and ifu_valid=1 and no flush, dec_valid=1 combinationally with dec_pc=ifu_pc and dec_inst=ifu_inst.
//   If dec_ready=1 that cycle, the entry is consumed and not written (count stays 0).
//   Otherwise it is written as a normal push. Zero-cycle latency when empty.
// - Not defined: no bypass path, 1-cycle minimum latency, decode outputs purely register-driven.
// TESTING
// - Reset: hold rst_n=0 mid-stream with count=3.
//   -> Immediately dec_valid=0, dec_pc=0, ifq_count=0, ifq_overflow=0, ifq_ready=1.
// - Fill/overflow: DEPTH=4, dec_ready=0, push PC 0,1,2,3.
//   -> ifq_count=4, ifq_ready=0.
//   Push PC 4 -> ifq_overflow=1, count=4. Then dec_ready=1 drains 0,1,2,3 and PC 4 never appears.
// - Streaming: dec_ready=1, ifu_valid=1, PC 0,1,2,... each cycle.
//   -> dec_pc equals ifu_pc delayed 1 cycle (0 cycles with IFQ_BYPASS_EN); ifq_count <= 1; no overflow.
// - Full push+pop: count=4 (PCs 10..13), ifu_valid with PC 14 and dec_ready=1 in the same cycle.
//   -> Count stays 4, no overflow, drain order 11,12,13,14.
// - Flush collision: count=2, flush=1 with ifu_valid (PC 0x40) and dec_ready=1 in the same cycle.
//   -> Next cycle count=0, dec_valid=0. PC 0x40 is never output.
// - Wrap-around: 20 sequential PCs with pseudo-random dec_ready (seeded).
//   -> Output sequence is exactly PC 0..19 in order, no overflow when ifu_valid is gated by ifq_ready.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: FIFO of {pc, inst} pairs between the IFU and decode,
// with flush on redirect and sticky overflow. Optional zero-latency bypass: IFQ_BYPASS_EN.
module ifu_fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ifu_valid,
  input  logic [PC_WIDTH-1:0]       ifu_pc,
  input  logic [INST_WIDTH-1:0]     ifu_inst,
  output logic                      ifq_ready,
  input  logic                      flush,
  output logic                      dec_valid,
  output logic [PC_WIDTH-1:0]       dec_pc,
  output logic [INST_WIDTH-1:0]     dec_inst,
  input  logic                      dec_ready,
  output logic [$clog2(DEPTH):0]    ifq_count,
  output logic                      ifq_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_bypass;
  logic w_bypass_take;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == FULL_CNT);
    w_pop         = ~w_empty & dec_ready;
`ifdef IFQ_BYPASS_EN
    w_bypass      = w_empty & ifu_valid & ~flush;
    w_bypass_take = w_bypass & dec_ready;
`else
    w_bypass      = 1'b0;
    w_bypass_take = 1'b0;
`endif
    // A bypassed entry consumed in the same cycle never touches the storage.
    w_push        = ifu_valid & (~w_full | w_pop) & ~w_bypass_take;
    w_drop        = ifu_valid & w_full & ~w_pop;
  end

  always_comb begin
    dec_valid = ~w_empty;
    dec_pc    = '0;
    dec_inst  = '0;
    if (!w_empty) begin
      dec_pc   = r_pc_mem[r_rd_ptr];
      dec_inst = r_inst_mem[r_rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (w_bypass) begin
      dec_valid = 1'b1;
      dec_pc    = ifu_pc;
      dec_inst  = ifu_inst;
    end
`endif
  end

  assign ifq_ready    = ~w_full;
  assign ifq_count    = r_count;
  assign ifq_overflow = r_overflow;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // NOTE: storage is deliberately not reset; entries are only observed when qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]   <= ifu_pc;
      r_inst_mem[r_wr_ptr] <= ifu_inst;
    end
  end

endmodule
